// File: rtl/pe_result_collector_pkg.sv
// pe_result_collector_pkg: shared collector state encodings and counter width.
package pe_result_collector_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int PKT_COUNT_W = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with extra-MSB wrap pointers.
module sync_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign count = wp - rp;
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (wr_en) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/pe_result_collector.sv
// pe_result_collector: buffers PE result packets into a FIFO and streams them out until the run completes.
module pe_result_collector
  import pe_result_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W+1:0]      pkt_in,
  input  logic                   pe_done,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_last,
  output logic                   overflow,
  output logic [PKT_COUNT_W-1:0] pkt_count,
  output logic                   done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [1:0] state, nxt;
  logic full, empty, wr, rd, in_valid, in_last, cap_en;
  logic [AW:0] count;
  logic [DATA_W:0] head;
  assign in_valid = pkt_in[DATA_W+1];
  assign in_last = pkt_in[DATA_W];
  // Once pe_done is high nothing more is captured, so the FIFO only shrinks.
  assign cap_en = (state != S_DONE) && !pe_done;
  assign rd = m_valid && m_ready;
  assign wr = in_valid && cap_en && (!full || rd);
  assign m_valid = !empty;
  assign m_data = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last = m_valid && (head[DATA_W] || (pe_done && count == (AW+1)'(1)));
  assign done = state == S_DONE;
  sync_fifo #(.W(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr),
    .wr_data(pkt_in[DATA_W:0]),
    .rd_en(rd),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb
    nxt = state == S_IDLE    ? (pe_done ? S_DRAIN : wr ? (in_last ? S_DRAIN : S_COLLECT) : S_IDLE) :
          state == S_COLLECT ? ((pe_done || (wr && in_last)) ? S_DRAIN : S_COLLECT) :
          state == S_DRAIN   ? ((empty && !wr) ? S_DONE : S_DRAIN) : S_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      overflow <= 1'b0;
      pkt_count <= '0;
    end else begin
      state <= nxt;
      if (in_valid && cap_en && full && !rd) overflow <= 1'b1;
      if (wr && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pe_result_collector.sv
// tb_pe_result_collector: directed checks of capture, backpressure, last handling, drain and reset.
module tb_pe_result_collector;
  logic clk = 1'b0, rst, pe_done, m_ready, m_valid, m_last, overflow, done;
  logic [33:0] pkt_in;
  logic [31:0] m_data;
  logic [15:0] pkt_count;
  int n_cmp = 0, n_err = 0;
  pe_result_collector #(.FIFO_DEPTH(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .pe_done(pe_done), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .overflow(overflow),
    .pkt_count(pkt_count), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [33:0] pk(input logic v, input logic l, input logic [31:0] d);
    return {v, l, d};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    pe_done = 1'b0;
    m_ready = 1'b0;
    pkt_in = pk(1'b1, 1'b0, 32'h55);
    step();
    step();
    rst = 1'b0;
    pkt_in = '0;
  endtask
  initial begin
    do_reset();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_done", done, 0);
    // single packet then pe_done
    pkt_in = pk(1'b1, 1'b0, 32'hDEADBEEF);
    step();
    pkt_in = '0;
    chk("single_valid", m_valid, 1);
    chk("single_data", m_data, 32'hDEADBEEF);
    chk("single_last_pre", m_last, 0);
    chk("single_count", pkt_count, 1);
    pe_done = 1'b1;
    #1;
    chk("single_last_forced", m_last, 1);
    m_ready = 1'b1;
    step();
    chk("single_popped", m_valid, 0);
    step();
    chk("single_done", done, 1);
    pkt_in = pk(1'b1, 1'b0, 32'h77);
    step();
    pkt_in = '0;
    chk("done_ignores_valid", m_valid, 0);
    chk("done_ignores_count", pkt_count, 1);
    // backpressure: 20 packets into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pkt_in = pk(1'b1, 1'b0, 32'(i));
      step();
    end
    pkt_in = '0;
    chk("bp_count", pkt_count, 16);
    chk("bp_overflow", overflow, 1);
    step();
    step();
    chk("bp_hold_data", m_data, 0);
    chk("bp_hold_valid", m_valid, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bp_word%0d", i), m_data, 64'(i));
      step();
    end
    chk("bp_empty", m_valid, 0);
    chk("bp_overflow_sticky", overflow, 1);
    // full FIFO with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pkt_in = pk(1'b1, 1'b0, 32'(i));
      step();
    end
    chk("fp_count16", pkt_count, 16);
    chk("fp_no_ovf_yet", overflow, 0);
    pkt_in = pk(1'b1, 1'b0, 32'd100);
    m_ready = 1'b1;
    step();
    pkt_in = '0;
    chk("fp_overflow", overflow, 0);
    chk("fp_count17", pkt_count, 17);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("fp_word%0d", i), m_data, 64'(i));
      step();
    end
    chk("fp_tail", m_data, 100);
    // last flag mid-stream
    do_reset();
    m_ready = 1'b1;
    pkt_in = pk(1'b1, 1'b0, 32'hA);
    step();
    chk("lf_a", m_data, 32'hA);
    chk("lf_a_last", m_last, 0);
    pkt_in = pk(1'b1, 1'b1, 32'hB);
    step();
    chk("lf_b", m_data, 32'hB);
    chk("lf_b_last", m_last, 1);
    pkt_in = pk(1'b1, 1'b0, 32'hC);
    step();
    pkt_in = '0;
    chk("lf_c", m_data, 32'hC);
    chk("lf_c_last", m_last, 0);
    chk("lf_count", pkt_count, 3);
    step();
    chk("lf_drained", m_valid, 0);
    chk("lf_not_done_yet", done, 0);
    step();
    chk("lf_done", done, 1);
    // pe_done with no packets
    do_reset();
    pe_done = 1'b1;
    m_ready = 1'b1;
    step();
    chk("np_valid1", m_valid, 0);
    step();
    chk("np_done", done, 1);
    chk("np_valid2", m_valid, 0);
    chk("np_count", pkt_count, 0);
    // reset mid-run with 5 words buffered
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pkt_in = pk(1'b1, 1'b0, 32'(i + 40));
      step();
    end
    chk("mr_count5", pkt_count, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pkt_in = '0;
    chk("mr_valid", m_valid, 0);
    chk("mr_count", pkt_count, 0);
    chk("mr_done", done, 0);
    pkt_in = pk(1'b1, 1'b0, 32'h12345678);
    step();
    pkt_in = '0;
    chk("mr_new_data", m_data, 32'h12345678);
    chk("mr_new_count", pkt_count, 1);
    pe_done = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("mr_new_last", m_last, 1);
    step();
    step();
    chk("mr_new_done", done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_result_collector.md
PE_RESULT_COLLECTOR -- requirements
Module: pe_result_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, power of two ≥4; number of buffered result packets.
REQ-002 Parameter DATA_W, default 32; payload width of a result packet.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst  input  1  reset; synchronous to clk, active-high.
REQ-005 pkt_in  input  DATA_W+2  PE result packet: bit[DATA_W+1] valid, bit[DATA_W] last flag, bits[DATA_W-1:0] payload.
REQ-006 pe_done  input  1  PE finished; level, stays high until rst.
REQ-007 m_valid  output  1  output stream word valid.
REQ-008 m_ready  input  1  downstream (host DMA) accepts word when m_valid & m_ready.
REQ-009 m_data  output  DATA_W  output payload.
REQ-010 m_last  output  1  marks final word of the run.
REQ-011 overflow  output  1  sticky; a packet was dropped because FIFO was full.
REQ-012 pkt_count  output  16  packets accepted into FIFO since reset, saturating at 16'hFFFF.
REQ-013 done  output  1  run complete and fully drained.

Function
REQ-014 Capture: each cycle pkt_in valid bit = 1 and FIFO not full, {last, payload} written to FIFO; one packet per valid cycle, no dedup.
REQ-015 Full: valid packet while FIFO holds FIFO_DEPTH entries is dropped, overflow set to 1 on the next edge, held until rst.
REQ-016 Simultaneous write and read when full: read frees the slot, write accepted in the same cycle, no overflow.
REQ-017 Output: FWFT FIFO; m_valid = FIFO non-empty; m_data/m_last = head entry; pop on m_valid & m_ready.
REQ-018 Latency: packet captured at edge N visible on m_valid/m_data after edge N (zero added cycles) when FIFO was empty.
REQ-019 m_data/m_last stable while m_valid=1 and m_ready=0.
REQ-020 Pointers: log2(FIFO_DEPTH)+1 bits; wrap modulo 2*FIFO_DEPTH; full/empty from MSB compare.
REQ-021 FSM states IDLE, COLLECT, DRAIN, DONE.
REQ-022 IDLE -> COLLECT on first accepted packet; IDLE -> DRAIN if pe_done=1 first.
REQ-023 COLLECT -> DRAIN when pe_done=1 or an accepted packet has last=1.
REQ-024 DRAIN: captures continue if pe_done=0; -> DONE when FIFO empty and no write in that cycle.
REQ-025 DRAIN with empty FIFO and no packet ever accepted: emit none; done still asserts.
REQ-026 DONE: done=1; pkt_in ignored; holds until rst.
REQ-027 m_last forced to 1 on the last FIFO word popped in DRAIN when pe_done=1 even if that packet's last bit was 0.
REQ-028 pkt_count increments by 1 per accepted packet only; never on drops.

Reset
REQ-029 On rst=1 at an edge: FSM=IDLE, pointers=0, m_valid=0, m_data=0, m_last=0, overflow=0, pkt_count=0, done=0.
REQ-030 rst mid-run discards FIFO contents; m_valid falls to 0 after that edge; pkt_in during rst ignored.

Structure
REQ-031 Packet field positions (valid, last, payload), PACKET_W and collector state encodings live in the shared config include alongside the existing Packet/SPacket macros.
REQ-032 One sub-module: sync_fifo (parameterised DATA_W+1 wide, FIFO_DEPTH deep, FWFT); FSM, counter and overflow logic in pe_result_collector.

Verification
REQ-033 Single packet: pkt_in={1,0,32'hDEADBEEF} one cycle, m_ready=1, then pe_done=1 -> one word DEADBEEF, m_last=1, pkt_count=1, done=1.
REQ-034 Backpressure: 20 consecutive packets 0..19, m_ready=0, depth 16 -> words 0..15 later emitted in order, overflow=1, pkt_count=16.
REQ-035 Full plus pop: FIFO full, m_ready=1 and new valid packet same cycle -> accepted, overflow stays 0.
REQ-036 Last flag: packets A,B(last=1),C -> A,B output, m_last on B, C accepted and output after B, done after drain.
REQ-037 pe_done with no packets -> m_valid never 1, done=1 within 2 cycles, pkt_count=0.
REQ-038 rst asserted with 5 words buffered -> m_valid=0, pkt_count=0, FSM IDLE next cycle; new run behaves as REQ-033.
